// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder block.
//   - cpustate encodings driven by the CPU control unit
//   - responder FSM state encodings
//   - bus width constants and the even-parity helper
package mem_responder_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'b00,
    CS_IN    = 2'b01,
    CS_CHECK = 2'b10,
    CS_RUN   = 2'b11
  } cpustate_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } resp_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus between the control unit (master) and the responder (slave).
//   addr/wdata/read/write : request from the CPU (AR/DR side)
//   rdata/ack/ready/err   : response from the responder
//
// Handshake: a request is a cycle where cpustate=RUN, ready=1 and exactly one
// of read/write is high; it is accepted on that rising edge. ready stays low
// until the request completes or aborts. ack is a one-cycle completion pulse,
// with rdata valid from the ack cycle until the next completed read. err is a
// one-cycle pulse; strobes seen while ready=0 only raise err.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              ready;
  logic              err;

  modport master (output addr, wdata, read, write,
                  input  rdata, ack, ready, err);
  modport slave  (input  addr, wdata, read, write,
                  output rdata, ack, ready, err);
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port program/data store with asynchronous read.
// Optional feature macro: MEM_PARITY_EN adds an even-parity column.
//   clk                  : write clock
//   cpu_we/addr/data     : CPU write port (has priority over the loader)
//   load_we/addr/data    : host loader write port
//   raddr_a/rdata_a/perr_a : CPU read port and parity-mismatch flag
//   raddr_b/rdata_b/perr_b : inspection read port and parity-mismatch flag
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  cpu_we,
  input  logic [DEPTH_LOG2-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_data,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic [DEPTH_LOG2-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  output logic                  perr_a,
  input  logic [DEPTH_LOG2-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  output logic                  perr_b
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DATA_W-1:0]     wdata;

  // CPU and loader writes never coincide (different cpustate), the mux
  // simply picks whichever is active.
  always_comb begin
    we    = cpu_we | load_we;
    waddr = cpu_we ? cpu_addr : load_addr;
    wdata = cpu_we ? cpu_data : load_data;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= even_parity(wdata);
  end

  assign perr_a = par_mem[raddr_a] != even_parity(rdata_a);
  assign perr_b = par_mem[raddr_b] != even_parity(rdata_b);
`else
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit CPU memory bus.
// Optional feature macro: MEM_PARITY_EN (parity check on CPU and CHECK reads).
//   clk, rst      : clock, asynchronous active-high reset
//   cpustate      : 01=IN (loader), 10=CHECK (inspect), 11=RUN (CPU), 00=idle
//   bus (slave)   : CPU request/response, see mem_responder_if
//   load_we/addr/data : host program loader (IN only)
//   chk_addr/chk_data : host inspection port (CHECK only), registered data
//   dbg_state     : current FSM state
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cpustate,
  mem_responder_if.slave        bus,
  input  logic                  load_we,
  input  logic [7:0]            load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic [7:0]            chk_addr,
  output logic [DATA_W-1:0]     chk_data,
  output resp_state_t           dbg_state
);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  resp_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, chk_data_q;
  logic              ack_q, err_q, chk_perr_q;
  logic              run, strobe, accept, complete, proto_err;
  logic              addr_ok, load_ok, chk_ok, cpu_we, load_we_eff;
  logic [ADDR_W-1:0] load_addr16, chk_addr16;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              perr_a, perr_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  assign load_addr16 = {8'h00, load_addr};
  assign chk_addr16  = {8'h00, chk_addr};
  assign addr_ok     = in_range(addr_q);
  assign load_ok     = in_range(load_addr16);
  assign chk_ok      = in_range(chk_addr16);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    complete  = 1'b0;
    proto_err = 1'b0;
    run       = (cpustate == CS_RUN);
    strobe    = bus.read | bus.write;
    unique case (state_q)
      ST_IDLE: begin
        if (run && strobe) begin
          if (bus.read && bus.write) begin
            proto_err = 1'b1;
          end else begin
            accept  = 1'b1;
            cnt_d   = 4'd0;
            state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          proto_err = strobe;
          if (cnt_q == WAIT_LAST) state_d = ST_RESP;
          else                    cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        // Leaving RUN here aborts: no ack is registered and no write commits.
        state_d   = ST_IDLE;
        complete  = run;
        proto_err = run & strobe;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_we      = complete & op_q & addr_ok;
  assign load_we_eff = (cpustate == CS_IN) & load_we & load_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      chk_data_q <= '0;
      chk_perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        op_q    <= bus.write;
      end
      ack_q <= complete;
      if (complete && !op_q) rdata_q <= addr_ok ? rdata_a : '0;
      // chk_perr_q delays the inspection parity error by one cycle so that
      // err follows the chk_data update.
      err_q <= proto_err
             | (complete & ~addr_ok)
             | (complete & ~op_q & addr_ok & perr_a)
             | chk_perr_q;
      if (cpustate == CS_CHECK) begin
        chk_data_q <= chk_ok ? rdata_b : '0;
        chk_perr_q <= chk_ok & perr_b;
      end else begin
        chk_perr_q <= 1'b0;
      end
    end
  end

  mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk       (clk),
    .cpu_we    (cpu_we),
    .cpu_addr  (addr_q[DEPTH_LOG2-1:0]),
    .cpu_data  (wdata_q),
    .load_we   (load_we_eff),
    .load_addr (load_addr16[DEPTH_LOG2-1:0]),
    .load_data (load_data),
    .raddr_a   (addr_q[DEPTH_LOG2-1:0]),
    .rdata_a   (rdata_a),
    .perr_a    (perr_a),
    .raddr_b   (chk_addr16[DEPTH_LOG2-1:0]),
    .rdata_b   (rdata_b),
    .perr_b    (perr_b)
  );

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.ready = (state_q == ST_IDLE);
  assign chk_data  = chk_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_CYCLES=0 and one
// with WAIT_CYCLES=3 share clock, reset, cpustate, loader and inspect inputs.
module tb_mem_responder;
  import mem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  cpustate;
  logic        load_we;
  logic [7:0]  load_addr, load_data, chk_addr;
  logic [7:0]  chk_data_w0, chk_data_w3;
  resp_state_t dbg_w0, dbg_w3;

  mem_responder_if bus_w0();
  mem_responder_if bus_w3();

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .cpustate(cpustate), .bus(bus_w0),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .chk_addr(chk_addr), .chk_data(chk_data_w0), .dbg_state(dbg_w0)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .cpustate(cpustate), .bus(bus_w3),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .chk_addr(chk_addr), .chk_data(chk_data_w3), .dbg_state(dbg_w3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [7:0] d);
    if (sel) begin
      bus_w3.read = rd; bus_w3.write = wr; bus_w3.addr = a; bus_w3.wdata = d;
    end else begin
      bus_w0.read = rd; bus_w0.write = wr; bus_w0.addr = a; bus_w0.wdata = d;
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  // One-cycle strobe, then watch a fixed window. lat counts edges after the
  // accept edge until ack is seen (-1 when no ack arrives).
  task automatic issue(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [7:0] d,
                       output int lat, output int n_ack, output int n_err,
                       output logic err_at_ack, output logic [7:0] rd_at_ack,
                       output logic rdy0, output logic rdy_ack);
    logic s_ack, s_err, s_rdy;
    logic [7:0] s_rd;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, a, d);
    lat = -1; n_ack = 0; n_err = 0; err_at_ack = 1'b0; rd_at_ack = 8'h00;
    rdy0 = 1'b0; rdy_ack = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (sel) begin
        s_ack = bus_w3.ack; s_err = bus_w3.err; s_rd = bus_w3.rdata; s_rdy = bus_w3.ready;
      end else begin
        s_ack = bus_w0.ack; s_err = bus_w0.err; s_rd = bus_w0.rdata; s_rdy = bus_w0.ready;
      end
      if (k == 0) rdy0 = s_rdy;
      if (s_err) n_err++;
      if (s_ack) begin
        n_ack++;
        if (lat < 0) begin
          lat = k; err_at_ack = s_err; rd_at_ack = s_rd; rdy_ack = s_rdy;
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          exp_lat;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  int lat, n_ack, n_err, cnt_ack, cnt_err;
  logic err_at_ack, rdy0, rdy_ack;
  logic [7:0] rd_at_ack;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 8'h00,  1, 8'h3C, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 8'hA5,  4, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 8'h00,  4, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0010, 8'h11, -1, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 8'h00,  4, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h12,  1, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0100, 8'h00,  1, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 8'h77,  1, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 8'h00,  1, 8'h12, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h00FF, 8'h5A,  1, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 8'h00,  1, 8'h5A, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 16'hFF05, 8'h00,  4, 8'h00, 1'b1};

    rst = 1'b1; cpustate = CS_IDLE;
    load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00; chk_addr = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_w0", bus_w0.ready, 1'b1);
    check("rst_ack_w0",   bus_w0.ack,   1'b0);
    check("rst_rdata_w0", bus_w0.rdata, 8'h00);
    check("rst_err_w3",   bus_w3.err,   1'b0);
    check("rst_chk_w3",   chk_data_w3,  8'h00);
    check("rst_state_w3", dbg_w3,       ST_IDLE);
    rst = 1'b0;

    // ---- loader ----
    cpustate = CS_IN;
    load_word(8'h05, 8'h3C);
    load_word(8'h20, 8'h44);
    load_word(8'h07, 8'h81);

    // ---- table-driven RUN transactions ----
    @(posedge clk); #1;
    cpustate = CS_RUN;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rd && !vecs[i].wr && vecs[i].exp_lat > 0) exp_q.push_back(vecs[i].exp_rdata);
      issue(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            lat, n_ack, n_err, err_at_ack, rd_at_ack, rdy0, rdy_ack);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_nack", i), n_ack, (vecs[i].exp_lat > 0) ? 1 : 0);
      check($sformatf("v%0d_nerr", i), n_err, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_ready_drop", i), rdy0, (vecs[i].exp_lat > 0) ? 1'b0 : 1'b1);
      if (n_ack > 0) begin
        check($sformatf("v%0d_err_at_ack", i), err_at_ack, vecs[i].exp_err);
        check($sformatf("v%0d_ready_at_ack", i), rdy_ack, 1'b1);
      end
      if (vecs[i].rd && !vecs[i].wr && vecs[i].exp_lat > 0 && exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (n_ack > 0) check($sformatf("v%0d_rdata", i), rd_at_ack, e);
      end
    end

    // ---- strobe while busy: err pulse, in-flight write still completes ----
    @(posedge clk); #1; drive(1'b1, 1'b0, 1'b1, 16'h0030, 8'h66);
    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b0, 16'h0031, 8'h00);
    @(posedge clk); #1; drive(1'b1, 1'b0, 1'b0, 16'h0031, 8'h00);
    @(negedge clk);
    check("busy_err", bus_w3.err, 1'b1);
    check("busy_ready", bus_w3.ready, 1'b0);
    cnt_ack = 0; cnt_err = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus_w3.ack) cnt_ack++;
      if (bus_w3.err) cnt_err++;
    end
    check("busy_inflight_ack", cnt_ack, 1);
    check("busy_inflight_err", cnt_err, 0);
    issue(1'b1, 1'b1, 1'b0, 16'h0030, 8'h00, lat, n_ack, n_err, err_at_ack, rd_at_ack, rdy0, rdy_ack);
    check("busy_readback", rd_at_ack, 8'h66);

    // ---- strobes ignored outside RUN; loader ignored outside IN ----
    @(posedge clk); #1; cpustate = CS_IN;
    issue(1'b0, 1'b1, 1'b0, 16'h0005, 8'h00, lat, n_ack, n_err, err_at_ack, rd_at_ack, rdy0, rdy_ack);
    check("notrun_ack", n_ack, 0);
    check("notrun_err", n_err, 0);
    @(posedge clk); #1; cpustate = CS_RUN;
    load_we = 1'b1; load_addr = 8'h05; load_data = 8'hEE;
    @(posedge clk); #1; load_we = 1'b0;

    // ---- abort mid-wait: no ack, write not committed ----
    @(posedge clk); #1; drive(1'b1, 1'b0, 1'b1, 16'h0020, 8'h99);
    @(posedge clk); #1; drive(1'b1, 1'b0, 1'b0, 16'h0020, 8'h99);
    @(posedge clk); #1; cpustate = CS_CHECK; chk_addr = 8'h20;
    cnt_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus_w3.ack) cnt_ack++;
    end
    check("abort_no_ack", cnt_ack, 0);
    check("abort_ready", bus_w3.ready, 1'b1);
    check("abort_state", dbg_w3, ST_IDLE);
    check("abort_chk_old", chk_data_w3, 8'h44);

    // ---- chk_data holds outside CHECK, registers one cycle in CHECK ----
    @(posedge clk); #1; cpustate = CS_IDLE; chk_addr = 8'h05;
    @(posedge clk); @(negedge clk);
    check("chk_hold", chk_data_w3, 8'h44);
    cpustate = CS_CHECK;
    #1;
    check("chk_reg_lat", chk_data_w3, 8'h44);
    @(posedge clk); @(negedge clk);
    check("chk_load_ignored", chk_data_w3, 8'h3C);
    check("chk_w0", chk_data_w0, 8'h3C);

    @(posedge clk); #1; cpustate = CS_RUN;
    issue(1'b1, 1'b1, 1'b0, 16'h0020, 8'h00, lat, n_ack, n_err, err_at_ack, rd_at_ack, rdy0, rdy_ack);
    check("abort_no_commit", rd_at_ack, 8'h44);

    // ---- async reset mid-wait ----
    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b0, 16'h0010, 8'h00);
    @(posedge clk); #1; drive(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    @(posedge clk); #1; rst = 1'b1;
    #1;
    check("rstmid_ready", bus_w3.ready, 1'b1);
    check("rstmid_ack",   bus_w3.ack,   1'b0);
    check("rstmid_rdata", bus_w3.rdata, 8'h00);
    check("rstmid_chk",   chk_data_w3,  8'h00);
    check("rstmid_state", dbg_w3,       ST_IDLE);
    @(posedge clk); #1; rst = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 8'h00, lat, n_ack, n_err, err_at_ack, rd_at_ack, rdy0, rdy_ack);
    check("rst_keeps_mem_lat", lat, 4);
    check("rst_keeps_mem", rd_at_ack, 8'hA5);

`ifdef MEM_PARITY_EN
    // ---- stored parity flip at 0x07 ----
    u_w0.u_mem.par_mem[7] = ~u_w0.u_mem.par_mem[7];
    issue(1'b0, 1'b1, 1'b0, 16'h0007, 8'h00, lat, n_ack, n_err, err_at_ack, rd_at_ack, rdy0, rdy_ack);
    check("par_lat", lat, 1);
    check("par_rdata", rd_at_ack, 8'h81);
    check("par_err", err_at_ack, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 8-bit CPU's memory bus.
- Answers the read/write strobes and 16-bit address issued by the control unit during RUN.
- Serves the host program loader during IN and the host inspection port during CHECK.
- Sits between the AR/DR datapath registers and the single-port program/data store; supports a configurable number of wait states.

Parameters:
- DEPTH_LOG2, 8, implemented words = 2**DEPTH_LOG2; addresses at or above this are out of range.
- WAIT_CYCLES, 0, extra cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpustate  in  2  01=IN, 10=CHECK, 11=RUN, 00=idle.
- addr  in  16  CPU address from AR.
- wdata  in  8  CPU write data (bus value when busmem is asserted).
- read  in  1  CPU read strobe.
- write  in  1  CPU write strobe.
- rdata  out  8  read data to bus (membus source).
- ack  out  1  one-cycle completion pulse.
- ready  out  1  high when a new request can be accepted.
- err  out  1  one-cycle protocol/range error pulse.
- load_we  in  1  host load write enable (IN only).
- load_addr  in  8  host load address.
- load_data  in  8  host load data.
- chk_addr  in  8  host inspect address (CHECK only).
- chk_data  out  8  registered inspect data.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - rdata=0x00, ack=0, err=0, ready=1, chk_data=0x00, wait counter=0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE, cpustate=11, exactly one of read/write high:
  - Latch addr, wdata and op.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
  - ready drops on the next cycle.
- WAIT: counter counts up from 0; at WAIT_CYCLES-1 go to RESP.
- RESP, lasting one cycle:
  - ack=1.
  - Read: rdata = mem[addr]. rdata holds until the next completed read.
  - Write: mem[addr] = wdata, committed on this edge.
  - Return to IDLE with ready=1.
- Latency: a request accepted at edge N gives ack high in cycle N+1+WAIT_CYCLES. With WAIT_CYCLES=0 this matches the control unit's fixed single-cycle timing.
- Error cases:
  - read and write both high in IDLE: no request is accepted, err=1 next cycle, state stays IDLE.
  - Any strobe while ready=0: ignored, err=1 pulse, the in-flight operation is unaffected.
  - addr[15:DEPTH_LOG2] nonzero: the request still completes with ack. Reads return 0x00, writes are dropped, and err pulses together with ack.
- cpustate leaves 11 during WAIT or RESP: abort to IDLE on the next edge. No ack, no write commit, ready=1.
- Strobes are ignored whenever cpustate is not 11.
- IN (cpustate=01): load_we=1 writes load_data to mem[load_addr] at the edge. Load inputs are ignored in every other state.
- CHECK (cpustate=10): chk_data is mem[chk_addr] registered one cycle; otherwise chk_data holds its value.
- Same-address write in RESP plus CHECK read cannot occur, because the states are mutually exclusive.

Optional Feature:
- Macro MEM_PARITY_EN.
- Defined:
  - Each word stores an even-parity bit, computed on CPU write and on load.
  - A CPU read or CHECK read with a parity mismatch asserts err together with ack (or one cycle after chk_data updates); data is still returned.
- Undefined: no parity storage; err arises only from protocol or range errors.

Decomposition:
- Shared package:
  - cpustate encodings CS_IN/CS_CHECK/CS_RUN.
  - Responder FSM state encodings.
  - DATA_W=8 and ADDR_W=16 constants.
- One sub-module, mem_array:
  - Write port muxed between CPU and loader.
  - Asynchronous read.
  - Optional parity column.

Test Plan:
- IN: load 0x3C at 0x05. RUN, WAIT_CYCLES=0: read addr=0x0005 → ack one cycle after accept, rdata=0x3C, ready back high the following cycle.
- WAIT_CYCLES=3, RUN: write 0xA5 to 0x0010, then read 0x0010 → ack 4 cycles after each accept, rdata=0xA5.
- read=1 and write=1 together → err pulse, no ack, mem[0x10] unchanged.
- Out of range, read addr=0x0100 with DEPTH_LOG2=8 → ack with rdata=0x00 and err=1. A write to 0x0100 does not alias to 0x00.
- Abort, WAIT_CYCLES=3: write accepted, then cpustate→10 mid-wait → no ack, and CHECK chk_addr=0x20 shows the old value. Assert rst mid-wait → outputs at reset values immediately.
- MEM_PARITY_EN: force a stored parity bit flip at 0x07, then CPU read 0x07 → ack, data returned, err=1.
